// File: rtl/emu_step_seq.sv
// Stimulus and step sequencer for a fixed-point analog emulator model: drives reset,
// input and step enables, captures one output sample per step and checks the last one.
module emu_step_seq #(
   parameter int WIDTH = 25,
   parameter int DEPTH = 32,
   parameter int CNT_W = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int NW = AW + 1
) (
   input  logic                    emu_clk,
   input  logic                    emu_rst_n,
   input  logic                    start,
   input  logic [NW-1:0]           num_steps,
   input  logic signed [WIDTH-1:0] stim_in,
   input  logic [CNT_W-1:0]        rst_cycles,
   input  logic [CNT_W-1:0]        settle_cycles,
   input  logic signed [WIDTH-1:0] exp_final,
   input  logic signed [WIDTH-1:0] tol,
   input  logic signed [WIDTH-1:0] v_out,
   output logic signed [WIDTH-1:0] v_in,
   output logic                    model_rst,
   output logic                    model_step,
   output logic                    busy,
   output logic                    done,
   output logic                    pass,
   output logic                    fail,
   output logic [NW-1:0]           steps_done,
   input  logic [AW-1:0]           cap_raddr,
   output logic signed [WIDTH-1:0] cap_rdata
);

   localparam int DW = WIDTH + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_RESET, S_SETTLE, S_CAPTURE, S_STEP, S_CHECK, S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [NW-1:0]           k_q, k_d;
   logic [NW-1:0]           k_inc;
   logic [NW-1:0]           num_q, num_d;
   logic [CNT_W-1:0]        settle_q, settle_d;
   logic signed [WIDTH-1:0] exp_q, exp_d;
   logic signed [WIDTH-1:0] tol_q, tol_d;
   logic signed [WIDTH-1:0] last_q, last_d;
   logic signed [WIDTH-1:0] v_in_q, v_in_d;
   logic                    pass_q, pass_d;
   logic                    fail_q, fail_d;
   logic [NW-1:0]           steps_done_q, steps_done_d;
   logic signed [WIDTH-1:0] cap_rdata_q, cap_rdata_d;
   logic                    cap_we;
   logic                    accept;

   logic signed [WIDTH-1:0] cap_mem [DEPTH];

   // Difference and magnitude carried at WIDTH+1 bits so no operand pair can overflow.
   function automatic logic within_tol(input logic signed [WIDTH-1:0] sample,
                                       input logic signed [WIDTH-1:0] expected,
                                       input logic signed [WIDTH-1:0] limit);
      logic signed [DW-1:0] diff;
      logic signed [DW-1:0] mag;
      diff = DW'(sample) - DW'(expected);
      mag  = diff[DW-1] ? -diff : diff;
      return !limit[WIDTH-1] && (mag <= DW'(limit));
   endfunction

   assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
   assign k_inc  = k_q + NW'(1);

   always_ff @(posedge emu_clk) begin
      if (!emu_rst_n) state_q <= S_IDLE;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: if (start) state_d = S_RESET;
         S_RESET:        if (cnt_q == '0) state_d = (num_q == '0) ? S_DONE : S_SETTLE;
         S_SETTLE:       if (cnt_q == '0) state_d = S_CAPTURE;
         S_CAPTURE:      state_d = (k_inc == num_q) ? S_CHECK : S_STEP;
         S_STEP:         state_d = S_SETTLE;
         S_CHECK:        state_d = S_DONE;
         default:        state_d = S_IDLE;
      endcase
   end

   always_comb begin
      model_rst  = 1'b0;
      model_step = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_q)
         S_IDLE:  model_rst = 1'b1;
         S_RESET: begin
            model_rst  = 1'b1;
            busy       = 1'b1;
            model_step = (cnt_q == '0);
         end
         S_SETTLE, S_CAPTURE, S_CHECK: busy = 1'b1;
         S_STEP: begin
            busy       = 1'b1;
            model_step = 1'b1;
         end
         S_DONE:  done = 1'b1;
         default: model_rst = 1'b1;
      endcase
   end

   // The counter is reused: RESET length first, then reloaded with the settle count.
   always_comb begin
      cnt_d        = cnt_q;
      k_d          = k_q;
      num_d        = num_q;
      settle_d     = settle_q;
      exp_d        = exp_q;
      tol_d        = tol_q;
      last_d       = last_q;
      v_in_d       = v_in_q;
      pass_d       = pass_q;
      fail_d       = fail_q;
      steps_done_d = steps_done_q;
      cap_we       = 1'b0;
      cap_rdata_d  = cap_mem[cap_raddr];
      if (accept) begin
         cnt_d        = (rst_cycles == '0) ? '0 : rst_cycles - CNT_W'(1);
         k_d          = '0;
         num_d        = (num_steps > NW'(DEPTH)) ? NW'(DEPTH) : num_steps;
         settle_d     = settle_cycles;
         exp_d        = exp_final;
         tol_d        = tol;
         v_in_d       = stim_in;
         pass_d       = 1'b0;
         fail_d       = 1'b0;
         steps_done_d = '0;
      end
      case (state_q)
         S_RESET, S_SETTLE: cnt_d = (cnt_q == '0) ? settle_q : cnt_q - CNT_W'(1);
         S_STEP:            cnt_d = settle_q;
         S_CAPTURE: begin
            cap_we       = 1'b1;
            last_d       = v_out;
            steps_done_d = k_inc;
            if (k_inc != num_q) k_d = k_inc;
         end
         S_CHECK: begin
            pass_d = within_tol(last_q, exp_q, tol_q);
            fail_d = !within_tol(last_q, exp_q, tol_q);
         end
         default: ;
      endcase
   end

   always_ff @(posedge emu_clk) begin
      if (!emu_rst_n) begin
         cnt_q        <= '0;
         k_q          <= '0;
         v_in_q       <= '0;
         pass_q       <= 1'b0;
         fail_q       <= 1'b0;
         steps_done_q <= '0;
         cap_rdata_q  <= '0;
      end else begin
         cnt_q        <= cnt_d;
         k_q          <= k_d;
         v_in_q       <= v_in_d;
         pass_q       <= pass_d;
         fail_q       <= fail_d;
         steps_done_q <= steps_done_d;
         cap_rdata_q  <= cap_rdata_d;
      end
   end

   // Run configuration and sample storage carry no reset; they are rewritten every run.
   always_ff @(posedge emu_clk) begin
      num_q    <= num_d;
      settle_q <= settle_d;
      exp_q    <= exp_d;
      tol_q    <= tol_d;
      last_q   <= last_d;
      if (cap_we) cap_mem[k_q[AW-1:0]] <= v_out;
   end

   assign v_in       = v_in_q;
   assign pass       = pass_q;
   assign fail       = fail_q;
   assign steps_done = steps_done_q;
   assign cap_rdata  = cap_rdata_q;

endmodule

// File: tb/tb_emu_step_seq.sv
// Bench for emu_step_seq: a ramp/hold plant model feeds v_out, and each run is
// compared against timing and result expectations computed from the run settings.
module tb_emu_step_seq;

   localparam int WIDTH = 25;
   localparam int DEPTH = 32;
   localparam int CNT_W = 8;
   localparam int AW    = 5;
   localparam int NW    = 6;

   logic                    emu_clk = 1'b0;
   logic                    emu_rst_n;
   logic                    start;
   logic [NW-1:0]           num_steps;
   logic signed [WIDTH-1:0] stim_in;
   logic [CNT_W-1:0]        rst_cycles;
   logic [CNT_W-1:0]        settle_cycles;
   logic signed [WIDTH-1:0] exp_final;
   logic signed [WIDTH-1:0] tol;
   logic signed [WIDTH-1:0] v_out;
   logic signed [WIDTH-1:0] v_in;
   logic                    model_rst;
   logic                    model_step;
   logic                    busy;
   logic                    done;
   logic                    pass;
   logic                    fail;
   logic [NW-1:0]           steps_done;
   logic [AW-1:0]           cap_raddr;
   logic signed [WIDTH-1:0] cap_rdata;

   int checks = 0;
   int failures = 0;

   int plant_base = 0;
   int plant_gain = 0;
   int plant_cnt = 0;

   emu_step_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .emu_clk(emu_clk), .emu_rst_n(emu_rst_n), .start(start), .num_steps(num_steps),
      .stim_in(stim_in), .rst_cycles(rst_cycles), .settle_cycles(settle_cycles),
      .exp_final(exp_final), .tol(tol), .v_out(v_out), .v_in(v_in),
      .model_rst(model_rst), .model_step(model_step), .busy(busy), .done(done),
      .pass(pass), .fail(fail), .steps_done(steps_done), .cap_raddr(cap_raddr),
      .cap_rdata(cap_rdata)
   );

   always #5 emu_clk = ~emu_clk;

   // Plant: a step counter cleared by model reset, scaled into an output value.
   always @(posedge emu_clk) begin
      if (model_rst)       plant_cnt <= 0;
      else if (model_step) plant_cnt <= plant_cnt + 1;
   end
   assign v_out = WIDTH'(plant_base + plant_cnt * plant_gain);

   task automatic chk(input string tag, input longint obs, input longint expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic do_run(input int n, input int stim, input int rstc, input int settle,
                         input int expf, input int t_tol, input int base, input int gain,
                         input int poke_cyc);
      int n_eff, r_eff, exp_busy, done_cyc, rst_cnt, nsteps, busy_cnt, vin_bad;
      int stepc[80];
      longint fin, d;
      logic exp_pass;
      n_eff    = (n > DEPTH) ? DEPTH : n;
      r_eff    = (rstc == 0) ? 1 : rstc;
      exp_busy = r_eff + n_eff * (settle + 3);
      @(negedge emu_clk);
      plant_base    = base;
      plant_gain    = gain;
      num_steps     = NW'(n);
      stim_in       = WIDTH'(stim);
      rst_cycles    = CNT_W'(rstc);
      settle_cycles = CNT_W'(settle);
      exp_final     = WIDTH'(expf);
      tol           = WIDTH'(t_tol);
      start         = 1'b1;
      done_cyc = 0; rst_cnt = 0; nsteps = 0; busy_cnt = 0; vin_bad = 0;
      for (int c = 1; c <= exp_busy + 20 && done_cyc == 0; c++) begin
         @(negedge emu_clk);
         start = 1'b0;
         if (c == 1) begin
            chk("accept_busy", longint'(busy), 1);
            chk("accept_done_clr", longint'(done), 0);
            chk("accept_pass_clr", longint'(pass), 0);
            chk("accept_fail_clr", longint'(fail), 0);
            chk("accept_steps_clr", longint'(steps_done), 0);
         end
         if (c == poke_cyc) begin
            start         = 1'b1;
            stim_in       = WIDTH'($urandom);
            num_steps     = NW'(1);
            rst_cycles    = CNT_W'(7);
            settle_cycles = CNT_W'(9);
            exp_final     = WIDTH'($urandom);
            tol           = WIDTH'(-5);
         end
         if (model_rst) rst_cnt++;
         if (model_step) begin
            if (nsteps < 80) stepc[nsteps] = c;
            nsteps++;
         end
         if (busy) busy_cnt++;
         if (v_in !== WIDTH'(stim)) vin_bad++;
         if (done) done_cyc = c;
      end
      chk("done_cycle", longint'(done_cyc), longint'(exp_busy + 1));
      chk("busy_cycles", longint'(busy_cnt), longint'(exp_busy));
      chk("model_rst_cycles", longint'(rst_cnt), longint'(r_eff));
      chk("v_in_held", longint'(vin_bad), 0);
      chk("step_count", longint'(nsteps), longint'((n_eff == 0) ? 1 : n_eff));
      for (int j = 0; j < nsteps && j < 80; j++)
         chk("step_cycle", longint'(stepc[j]), longint'(r_eff + j * (settle + 3)));
      chk("steps_done", longint'(steps_done), longint'(n_eff));
      if (n_eff == 0) begin
         chk("pass_empty", longint'(pass), 0);
         chk("fail_empty", longint'(fail), 0);
      end else begin
         fin = longint'(base) + longint'(n_eff - 1) * longint'(gain);
         d = fin - longint'(expf);
         if (d < 0) d = -d;
         exp_pass = (t_tol >= 0) && (d <= longint'(t_tol));
         chk("pass", longint'(pass), longint'(exp_pass));
         chk("fail", longint'(fail), longint'(!exp_pass));
      end
      for (int i = 0; i < n_eff; i++) begin
         @(negedge emu_clk);
         cap_raddr = AW'(i);
         @(negedge emu_clk);
         chk("cap_rdata", longint'(cap_rdata), longint'(base) + longint'(i) * longint'(gain));
      end
      chk("done_sticky", longint'(done), 1);
   endtask

   initial begin
      int reached;
      int rn, rsettle, rrst, rbase, rgain, rexp, rtol, rneff;
      emu_rst_n = 1'b0; start = 1'b1; num_steps = '0; stim_in = '0; rst_cycles = '0;
      settle_cycles = '0; exp_final = '0; tol = '0; cap_raddr = '0;
      repeat (3) @(negedge emu_clk);
      chk("rst_model_rst", longint'(model_rst), 1);
      chk("rst_model_step", longint'(model_step), 0);
      chk("rst_busy_over_start", longint'(busy), 0);
      chk("rst_done", longint'(done), 0);
      chk("rst_pass", longint'(pass), 0);
      chk("rst_fail", longint'(fail), 0);
      chk("rst_v_in", longint'(v_in), 0);
      chk("rst_steps_done", longint'(steps_done), 0);
      chk("rst_cap_rdata", longint'(cap_rdata), 0);
      start = 1'b0;
      emu_rst_n = 1'b1;
      @(negedge emu_clk);
      chk("idle_model_rst", longint'(model_rst), 1);

      // ramp run with the reference timing
      do_run(3, 7, 2, 0, 2, 0, 0, 1, 0);
      // tolerance window
      do_run(2, 300, 1, 1, 100, 3, 103, 0, 0);
      do_run(2, -300, 1, 1, 100, 3, 104, 0, 0);
      do_run(2, 12, 1, 0, -100, 2, -98, 0, 0);
      do_run(2, 13, 1, 0, 50, -1, 50, 0, 0);
      // limits
      do_run(0, 11, 3, 2, 0, 5, 0, 1, 0);
      do_run(40, 5, 1, 0, 31, 0, 0, 1, 0);
      // settle spacing
      do_run(4, 9, 2, 5, 3, 0, 0, 1, 0);
      // start pulsed mid-run is ignored
      do_run(5, 21, 2, 1, 40, 0, 0, 10, 6);

      // abort during the settle of sample 2
      @(negedge emu_clk);
      plant_base = 0; plant_gain = 1; num_steps = NW'(4); stim_in = WIDTH'(123);
      rst_cycles = CNT_W'(1); settle_cycles = CNT_W'(3); exp_final = '0; tol = '0;
      start = 1'b1;
      @(negedge emu_clk);
      start = 1'b0;
      reached = 0;
      for (int i = 0; i < 100 && reached == 0; i++) begin
         @(negedge emu_clk);
         if (steps_done == NW'(2)) reached = 1;
      end
      chk("abort_reach", longint'(reached), 1);
      @(negedge emu_clk);
      emu_rst_n = 1'b0;
      @(negedge emu_clk);
      chk("abort_model_rst", longint'(model_rst), 1);
      chk("abort_model_step", longint'(model_step), 0);
      chk("abort_v_in", longint'(v_in), 0);
      chk("abort_busy", longint'(busy), 0);
      chk("abort_done", longint'(done), 0);
      chk("abort_steps_done", longint'(steps_done), 0);
      emu_rst_n = 1'b1;
      do_run(4, 77, 1, 3, 3, 0, 0, 1, 0);

      // randomized runs
      for (int r = 0; r < 6; r++) begin
         rn      = int'($urandom_range(1, 36));
         rsettle = int'($urandom_range(0, 3));
         rrst    = int'($urandom_range(0, 3));
         rbase   = int'($urandom_range(0, 2000)) - 1000;
         rgain   = int'($urandom_range(0, 40)) - 20;
         rneff   = (rn > DEPTH) ? DEPTH : rn;
         rexp    = rbase + (rneff - 1) * rgain + int'($urandom_range(0, 8)) - 4;
         rtol    = int'($urandom_range(0, 6)) - 1;
         do_run(rn, int'($urandom_range(0, 1000000)) - 500000, rrst, rsettle,
                rexp, rtol, rbase, rgain, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
